// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decoder with a 2-entry skid buffer.
// Define DECODE_CSR_EN to decode the Zicsr instructions; otherwise they are illegal.

package defs;
  localparam int BIN_DIG = 32;

  // Keys are the opcode-identifying instruction fields packed low-aligned.
  typedef enum logic [16:0] {
    ADD    = 17'h00033, SUB   = 17'h08033, SLL   = 17'h000B3, SLT    = 17'h00133,
    SLTU   = 17'h001B3, XOR   = 17'h00233, SRL   = 17'h002B3, SRA    = 17'h082B3,
    OR     = 17'h00333, AND   = 17'h003B3,
    SLLI   = 17'h00093, SRLI  = 17'h00293, SRAI  = 17'h08293,
    ADDI   = 17'h00013, SLTI  = 17'h00113, SLTIU = 17'h00193, XORI   = 17'h00213,
    ORI    = 17'h00313, ANDI  = 17'h00393,
    LB     = 17'h00003, LH    = 17'h00083, LW    = 17'h00103, LBU    = 17'h00203,
    LHU    = 17'h00283, JALR  = 17'h00067,
    SB     = 17'h00023, SH    = 17'h000A3, SW    = 17'h00123,
    BEQ    = 17'h00063, BNE   = 17'h000E3, BLT   = 17'h00263, BGE    = 17'h002E3,
    BLTU   = 17'h00363, BGEU  = 17'h003E3,
    LUI    = 17'h00037, AUIPC = 17'h00017, JAL   = 17'h0006F,
    FENCE  = 17'h0000F, FENCE_I = 17'h0008F,
    // ECALL and EBREAK share this key; execute tells them apart by imm[0].
    ECALL  = 17'h00073,
    CSRRW  = 17'h000F3, CSRRS = 17'h00173, CSRRC = 17'h001F3, CSRRWI = 17'h002F3,
    CSRRSI = 17'h00373, CSRRCI = 17'h003F3
  } key_e;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
endpackage

module decode_stage #(
  parameter int XLEN = defs::BIN_DIG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [16:0]     out_key,
  output logic [2:0]      out_fmt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_we,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [16:0]     key;
    logic [2:0]      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            we;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [16:0]     key_c;
  logic            legal, wr;
  entry_t          dec;

  always_comb begin
    op    = in_instr[6:0];
    f3    = in_instr[14:12];
    f7    = in_instr[31:25];
    rd_f  = in_instr[11:7];
    rs1_f = in_instr[19:15];
    rs2_f = in_instr[24:20];
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // funct7 only participates for OP, the shift-immediates and ECALL/EBREAK.
    if (op == 7'h33 || (op == 7'h73 && f3 == 3'd0) || (op == 7'h13 && f3[1:0] == 2'b01))
      key_c = {f7, f3, op};
    else if (op == 7'h37 || op == 7'h17 || op == 7'h6F)
      key_c = {10'b0, op};
    else
      key_c = {7'b0, f3, op};

    dec    = '0;
    dec.pc = in_pc;
    legal  = 1'b1;
    wr     = 1'b0;
    case (key_c)
      defs::ADD, defs::SUB, defs::SLL, defs::SLT, defs::SLTU,
      defs::XOR, defs::SRL, defs::SRA, defs::OR, defs::AND: begin
        dec.fmt = defs::FMT_R;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        wr      = 1'b1;
      end
      defs::SLLI, defs::SRLI, defs::SRAI: begin
        dec.fmt = defs::FMT_I;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = {{(XLEN-5){1'b0}}, rs2_f};
        wr      = 1'b1;
      end
      defs::ADDI, defs::SLTI, defs::SLTIU, defs::XORI, defs::ORI, defs::ANDI,
      defs::LB, defs::LH, defs::LW, defs::LBU, defs::LHU, defs::JALR: begin
        dec.fmt = defs::FMT_I;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = imm_i;
        wr      = 1'b1;
      end
      defs::FENCE, defs::FENCE_I: begin
        dec.fmt = defs::FMT_I;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = imm_i;
      end
      defs::ECALL: begin
        legal   = (in_instr[31:21] == 11'd0) && (rs1_f == 5'd0) && (rd_f == 5'd0);
        dec.fmt = defs::FMT_I;
        dec.imm = imm_i;
      end
`ifdef DECODE_CSR_EN
      defs::CSRRW, defs::CSRRS, defs::CSRRC,
      defs::CSRRWI, defs::CSRRSI, defs::CSRRCI: begin
        dec.fmt = defs::FMT_I;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = {{(XLEN-12){1'b0}}, in_instr[31:20]};
        wr      = 1'b1;
      end
`endif
      defs::SB, defs::SH, defs::SW: begin
        dec.fmt = defs::FMT_S;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        dec.imm = imm_s;
      end
      defs::BEQ, defs::BNE, defs::BLT, defs::BGE, defs::BLTU, defs::BGEU: begin
        dec.fmt = defs::FMT_B;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        dec.imm = imm_b;
      end
      defs::LUI, defs::AUIPC: begin
        dec.fmt = defs::FMT_U;
        dec.rd  = rd_f;
        dec.imm = imm_u;
        wr      = 1'b1;
      end
      defs::JAL: begin
        dec.fmt = defs::FMT_J;
        dec.rd  = rd_f;
        dec.imm = imm_j;
        wr      = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.fmt     = defs::FMT_ILL;
      dec.illegal = 1'b1;
    end else begin
      dec.key = key_c;
      dec.we  = wr & (|dec.rd);
    end
  end

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = dec;
          state_d = ONE;
        end
        ONE: begin
          if (accept && deliver) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = TWO;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        TWO: if (deliver) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_pc      = main_q.pc;
  assign out_key     = main_q.key;
  assign out_fmt     = main_q.fmt;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_imm     = main_q.imm;
  assign out_we      = main_q.we;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage.

module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_we, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [16:0] out_key;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_key(out_key),
    .out_fmt(out_fmt), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_we(out_we), .out_illegal(out_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] key, input logic [31:0] fmt,
                           input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] we, input logic [31:0] ill,
                           input logic [31:0] pc);
    check_eq({tag, ".valid"}, 32'(out_valid), 1);
    check_eq({tag, ".key"}, 32'(out_key), key);
    check_eq({tag, ".fmt"}, 32'(out_fmt), fmt);
    check_eq({tag, ".rd"}, 32'(out_rd), rd);
    check_eq({tag, ".rs1"}, 32'(out_rs1), rs1);
    check_eq({tag, ".rs2"}, 32'(out_rs2), rs2);
    check_eq({tag, ".imm"}, out_imm, imm);
    check_eq({tag, ".we"}, 32'(out_we), we);
    check_eq({tag, ".illegal"}, 32'(out_illegal), ill);
    check_eq({tag, ".pc"}, out_pc, pc);
  endtask

  // One instruction through an empty buffer with out_ready held high.
  task automatic single(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] key, input logic [31:0] fmt, input logic [31:0] rd,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] we, input logic [31:0] ill);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    @(negedge clk);
    in_valid = 1'b0;
    check_out(tag, key, fmt, rd, rs1, rs2, imm, we, ill, pc);
    @(negedge clk);
    check_eq({tag, ".drained"}, 32'(out_valid), 0);
  endtask

  // Fill both entries, then kill with flush or rst while a new instruction is offered.
  task automatic fill_and_kill(input bit use_rst);
    string t;
    int    seen;
    t = use_rst ? "rst" : "flush";
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 32'h500;
    @(negedge clk);
    in_pc = 32'h504;
    @(negedge clk);
    check_eq({t, ".full_ready"}, 32'(in_ready), 0);
    check_eq({t, ".full_pc"}, out_pc, 32'h500);
    in_pc    = 32'h508;
    in_instr = 32'h00200113;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq({t, ".valid"}, 32'(out_valid), 0);
    check_eq({t, ".in_ready"}, 32'(in_ready), 1);
    if (use_rst) begin
      check_eq("rst.key", 32'(out_key), 0);
      check_eq("rst.pc", out_pc, 0);
      check_eq("rst.imm", out_imm, 0);
      check_eq("rst.rd", 32'(out_rd), 0);
      check_eq("rst.we", 32'(out_we), 0);
    end
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq({t, ".ghost"}, seen, 0);
  endtask

  logic [31:0] got_pc[$];
  int          idx;
  bit          acc;
  int          seen1;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("reset.valid", 32'(out_valid), 0);
    check_eq("reset.in_ready", 32'(in_ready), 1);
    check_eq("reset.key", 32'(out_key), 0);
    check_eq("reset.pc", out_pc, 0);
    check_eq("reset.imm", out_imm, 0);
    check_eq("reset.fmt", 32'(out_fmt), 0);
    check_eq("reset.illegal", 32'(out_illegal), 0);

    single("addi", 32'hFFF00093, 32'h100, 32'h013, 1, 1, 0, 0, 32'hFFFFFFFF, 1, 0);
    single("addi_x0", 32'h00000013, 32'h104, 32'h013, 1, 0, 0, 0, 0, 0, 0);
    single("srai", 32'h40735293, 32'h108, 32'h08293, 1, 5, 6, 0, 7, 1, 0);
    single("lui", 32'h123453B7, 32'h10C, 32'h037, 4, 7, 0, 0, 32'h12345000, 1, 0);
    single("sw", 32'h0020A423, 32'h110, 32'h123, 2, 0, 1, 2, 8, 0, 0);
    single("zero", 32'h00000000, 32'h444, 0, 7, 0, 0, 0, 0, 0, 1);
    single("ecall", 32'h00000073, 32'h448, 32'h073, 1, 0, 0, 0, 0, 0, 0);
    single("ecall_rd1", 32'h000000F3, 32'h44C, 0, 7, 0, 0, 0, 0, 0, 1);
`ifdef DECODE_CSR_EN
    single("csrrw", 32'h300110F3, 32'h450, 32'h0F3, 1, 1, 2, 0, 32'h300, 1, 0);
`else
    single("csrrw", 32'h300110F3, 32'h450, 0, 7, 0, 0, 0, 0, 0, 1);
`endif

    // SUB then BEQ back to back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h402081B3;
    in_pc     = 32'h180;
    @(negedge clk);
    in_instr = 32'hFE000EE3;
    in_pc    = 32'h184;
    check_out("sub", 32'h08033, 0, 3, 1, 2, 0, 1, 0, 32'h180);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("beq", 32'h063, 3, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h184);
    @(negedge clk);
    check_eq("beq.drained", 32'(out_valid), 0);

    // Backpressure: four offered, two accepted, then drain in order.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && got_pc.size() < 4; c++) begin
      if (c == 4) out_ready = 1'b1;
      in_valid = (idx < 4);
      in_instr = 32'h00000013 | ((idx + 1) << 7);
      in_pc    = 32'h200 + 4 * idx;
      if (c < 2) check_eq($sformatf("bp.in_ready_c%0d", c), 32'(in_ready), 1);
      if (c == 2 || c == 3) check_eq($sformatf("bp.in_ready_c%0d", c), 32'(in_ready), 0);
      acc = in_valid & in_ready;
      if (out_valid && out_ready) got_pc.push_back(out_pc);
      @(negedge clk);
      if (acc) idx++;
      if (c == 3) check_eq("bp.accepted", idx, 2);
    end
    in_valid = 1'b0;
    check_eq("bp.count", got_pc.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_pc.size()) check_eq($sformatf("bp.order%0d", k), got_pc[k], 32'h200 + 4 * k);
    check_eq("bp.empty", 32'(out_valid), 0);

    fill_and_kill(1'b0);
    fill_and_kill(1'b1);

    // Flush with in_ready high still drops the offered instruction.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00300193;
    in_pc     = 32'h600;
    @(negedge clk);
    in_pc = 32'h604;
    check_eq("flush1.in_ready", 32'(in_ready), 1);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush1.valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    seen1 = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen1++;
    end
    check_eq("flush1.ghost", seen1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction decoder between fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake and matches it against the team's opcode encodings in `defs`. Delivers the matched encoding key, register indices, sign-extended immediate and format class to execute, with a 2-entry skid buffer so upstream `in_ready` is a pure register output.

## Interface
- `XLEN`, default `defs::BIN_DIG` (32): instruction, PC and immediate width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered instructions (branch redirect).
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_instr` in 32, `in_pc` in 32: fetched instruction and its PC.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_pc` out 32: PC of the delivered instruction.
- `out_key` out 17: matched `defs` enum value, zero-extended; 0 if illegal.
- `out_fmt` out 3: format class. 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register indices; a field the format does not use is 0.
- `out_imm` out 32: immediate, sign-extended per format.
- `out_we` out 1: instruction writes rd, and rd is not 0.
- `out_illegal` out 1: no encoding matched.

## Operation
- Key formation:
  - R, SLLI/SRLI/SRAI and ECALL/EBREAK use `{funct7, funct3, opcode}` (17 bits).
  - B, S, I_a, FENCE and CSR use `{funct3, opcode}` (10 bits).
  - JAL uses `opcode`. LUI (0x37) and AUIPC (0x17) use `opcode`.
- ECALL/EBREAK additionally require rs1 = rd = 0 and imm[11:1] per encoding; otherwise the instruction is illegal.
- Immediates:
  - I: `instr[31:20]` sign-extended.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - Shift-immediate: shamt `instr[24:20]` zero-extended.
  - CSR: csr address `instr[31:20]` zero-extended.
- Writes rd: R, I (except FENCE/FENCE_I/ECALL/EBREAK), U, J, CSR. S and B report `out_rd` = 0.
- Illegal: all decoded fields 0, `out_fmt` = 7, `out_illegal` = 1, `out_we` = 0. `out_pc` is still valid. The instruction is passed downstream, not dropped.
- Buffer: two entries, main and skid. Order is strictly preserved.
  - An instruction is accepted when `in_valid & in_ready`.
  - An instruction is delivered when `out_valid & out_ready`.
  - Decode is combinational on input; the result is registered into an entry.
- Buffer state machine:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without deliver.
  - TWO → ONE on deliver.
  - ONE → EMPTY on deliver without accept.
  - ONE stays in ONE on simultaneous accept and deliver.
  - TWO never accepts.

## Timing
- Reset values: `out_valid` = 0; all `out_*` data fields = 0; `in_ready` = 1 from the first cycle after reset release; state EMPTY.
- Latency: accept at edge N → `out_valid` from edge N.
- Throughput: 1 instruction/cycle while `out_ready` = 1.
- `in_ready` = registered (state != TWO). It deasserts the cycle after the second entry fills without a deliver.
- Output data is held stable while `out_valid & !out_ready`.
- `flush`: state → EMPTY at the next edge and `out_valid` = 0. Any `in_valid` in the flush cycle is dropped, even if `in_ready` = 1. Any delivery in the flush cycle counts as delivered.
- `rst` mid-stream behaves like `flush` and also zeroes the data registers. `rst` has priority over `flush`.

## Configuration
- `DECODE_CSR_EN` defined: the six CSR keys (0x0F3–0x3F3) decode as format I, with imm = csr address and `out_we` per rd.
- `DECODE_CSR_EN` undefined: all SYSTEM opcodes with funct3 != 0 decode as illegal. This removes the CSR match logic.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093) at pc 0x100:
  - the next cycle gives `out_key` = 0x013, `out_fmt` = 1, rd = 1, rs1 = 0, `out_imm` = 0xFFFFFFFF, `out_we` = 1, `out_pc` = 0x100.
- SUB x3,x1,x2 (0x402081B3), then BEQ x0,x0,-4 (0xFE000EE3) back-to-back:
  - first result: key 0x08033, fmt 0, rd/rs1/rs2 = 3/1/2;
  - second result: key 0x063, fmt 3, imm = 0xFFFFFFFC, rd = 0, `out_we` = 0.
- `out_ready` = 0 for 4 cycles while 4 instructions are offered:
  - exactly 2 are accepted, and `in_ready` = 0 from the 3rd cycle on;
  - after `out_ready` = 1, all 4 emerge in order with no duplicates.
- CSRRW x1,0x300,x2 (0x300110F3):
  - with `DECODE_CSR_EN`: key 0x0F3, imm = 0x00000300, `out_we` = 1;
  - without it: `out_illegal` = 1, fmt = 7, `out_we` = 0.
- 0x00000000 → `out_illegal` = 1, key = 0, `out_pc` preserved.
- ECALL with rd = 1 → illegal.
- With 2 entries held, assert `flush` together with `in_valid`:
  - the next cycle gives `out_valid` = 0 and `in_ready` = 1, and the offered instruction never appears.
  - Repeat the same sequence using `rst` and confirm the same result, plus all-zero outputs.
